// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared types, constants and address helpers for the data-memory initiator
package dmem_access_ctrl_pkg;

  localparam int DMEM_DW    = 32;
  localparam int DMEM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  function automatic logic [31:0] byte_to_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Legal means word aligned and inside the word array.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (byte_to_word(addr) < depth);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - request/response channels and memory strobes of the data-memory initiator
interface dmem_access_ctrl_if
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DW = DMEM_DW
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          Ewr;
  logic          Erd;
  logic [31:0]   Addr;
  logic [DW-1:0] RDir;
  logic [DW-1:0] MOut;

  // slave: the controller; master: datapath plus data memory around it
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, MOut,
    output req_ready, rsp_valid, rsp_data, rsp_err, Ewr, Erd, Addr, RDir
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, MOut,
    input  req_ready, rsp_valid, rsp_data, rsp_err, Ewr, Erd, Addr, RDir
  );

endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - one-at-a-time load/store initiator driving the data memory strobes
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int WAIT_CYC = 0,
  parameter int DW       = DMEM_DW
) (
  input  logic            clk,
  input  logic            rst,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ewr_q, ewr_d;
  logic          erd_q, erd_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] rdir_q, rdir_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ewr_q       <= 1'b0;
      erd_q       <= 1'b0;
      addr_q      <= '0;
      rdir_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ewr_q       <= ewr_d;
      erd_q       <= erd_d;
      addr_q      <= addr_d;
      rdir_q      <= rdir_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ewr_d       = ewr_q;
    erd_d       = erd_q;
    addr_d      = addr_q;
    rdir_d      = rdir_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!addr_legal(bus.req_addr, DEPTH)) begin
            // Bad address: answer straight away without touching the memory.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ACCESS;
            addr_d  = byte_to_word(bus.req_addr);
            rdir_d  = bus.req_we ? bus.req_wdata : '0;
            ewr_d   = bus.req_we;
            erd_d   = !bus.req_we;
            cnt_d   = WAIT_LD;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ewr_d       = 1'b0;
          erd_d       = 1'b0;
          rdir_d      = '0;
          rsp_data_d  = erd_q ? bus.MOut : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        rdir_d = '0;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.Ewr       = ewr_q;
  assign bus.Erd       = erd_q;
  assign bus.Addr      = addr_q;
  assign bus.RDir      = rdir_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface (`Ewr`/`Erd`/`Addr`/`RDir`/`MOut`).
- Accepts one load or store request at a time from the datapath over a valid/ready handshake.
- Converts byte address to word index, checks alignment and range, and drives the memory strobes for a fixed access window.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Sits between the pipeline's memory stage and the data memory.

Parameters:
- DEPTH, 32, number of 32-bit words in the data memory; legal word index 0..DEPTH-1.
- WAIT_CYC, 0, extra cycles the strobe is held before read data is sampled (0..15).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  DW  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DW  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range request.
- Ewr  out  1  memory write strobe.
- Erd  out  1  memory read strobe.
- Addr  out  32  word index to memory (req_addr >> 2).
- RDir  out  DW  write data to memory.
- MOut  in  DW  read data from memory.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`rst`).
- All outputs are registered except `req_ready`, which is (state==IDLE) && !rst.
- Reset values:
  - state = IDLE; counter = 0.
  - `Ewr` = 0, `Erd` = 0, `Addr` = 0, `RDir` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Request is accepted on an edge where `req_valid` && `req_ready`. The request is latched at that edge.
  - If req_addr[1:0] != 0, or (req_addr >> 2) >= DEPTH: go to RESP with `rsp_err` = 1 and `rsp_data` = 0. No strobe is ever asserted.
  - Otherwise: go to ACCESS. Drive `Addr` = req_addr >> 2 and `RDir` = req_wdata (store) or 0 (load). Assert exactly one of `Ewr` (req_we=1) or `Erd` (req_we=0). Load counter = WAIT_CYC.
- ACCESS:
  - The strobe, `Addr` and `RDir` are held constant.
  - While counter > 0, decrement it.
  - When counter == 0, at that edge:
    - Deassert both strobes.
    - For a load, capture `MOut` into `rsp_data`; for a store, set `rsp_data` = 0.
    - Set `rsp_err` = 0, `rsp_valid` = 1, and go to RESP.
  - Strobe window is exactly WAIT_CYC+1 cycles.
- RESP:
  - `rsp_valid`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid` && `rsp_ready`: clear `rsp_valid` and go to IDLE.
  - `Addr` keeps its last value; `RDir` is cleared to 0.
- Latency: request accepted at edge N.
  - Strobe is high in cycles N+1 .. N+1+WAIT_CYC.
  - `rsp_valid` is first high in cycle N+2+WAIT_CYC.
  - Error responses: `rsp_valid` is high in cycle N+1.
- Throughput: the next request can be accepted no earlier than the cycle after the response handshake. No overlap of requests.
- Invariants:
  - `Ewr` and `Erd` are never both 1.
  - Strobes are 0 outside ACCESS.
  - `req_valid` held while `req_ready` = 0 has no effect.
- Reset mid-operation: at the reset edge, the access is abandoned, strobes drop, and no response is issued. An interrupted store may have partially updated memory; this is not reported.
- Boundary addresses:
  - Word DEPTH-1 (byte 4*(DEPTH-1)) is legal.
  - Byte 4*DEPTH is out of range and errors.
  - Address 0 is legal.

Decomposition:
- Shared memory-interface package:
  - state enum (IDLE, ACCESS, RESP).
  - DW and default DEPTH constants.
  - function `byte_to_word(addr)`.
  - function `addr_legal(addr, depth)`.
- No sub-module needed. Address check is a small combinational function, and the FSM plus counter is a single block.

Test Plan:
- Store/load, WAIT_CYC=0:
  - Store addr 0x10, data 0xDEADBEEF: `Ewr`=1 for exactly 1 cycle with `Addr`=4, `RDir`=0xDEADBEEF. Then `rsp_valid`=1, `rsp_err`=0, `rsp_data`=0.
  - Load 0x10: `Erd`=1 for 1 cycle, `Addr`=4. Then `rsp_data`=0xDEADBEEF.
- WAIT_CYC=3:
  - Load accepted at edge N: `Erd` high cycles N+1..N+4. `rsp_valid` first high at N+5 with `rsp_data` = `MOut` sampled at the N+5 edge.
- Errors:
  - Load 0x0000_0006 (misaligned): `rsp_err`=1 in cycle N+1, `Ewr`/`Erd` never high.
  - Store 0x80 with DEPTH=32: `rsp_err`=1, `Ewr` never high.
  - Load 0x7C: legal, `Addr`=31.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles: `rsp_valid`/`rsp_data` stable and `req_ready`=0 throughout.
  - Assert `rsp_ready`: IDLE next cycle, and a back-to-back queued request is accepted that cycle.
- Reset in ACCESS:
  - WAIT_CYC=3, assert `rst` on the 2nd strobe cycle: the next cycle shows `Erd`=0, `rsp_valid`=0, `req_ready`=0 during reset and `req_ready`=1 after.
  - No response is ever emitted for the aborted request.
